// File: rtl/alu_pkg.sv
// Shared types for the sequential X9 ALU: opcodes, FSM states, flag bundle and opcode legality.
// Legality of opcode 0100 depends on the ALU_SEQ_MUL_EN macro.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_ADC   = 4'b0010,
    OP_PASSA = 4'b0011,
    OP_MUL   = 4'b0100,
    OP_PASSB = 4'b0101,
    OP_RSVD  = 4'b0110,
    OP_NOR   = 4'b0111,
    OP_XOR   = 4'b1000,
    OP_AND   = 4'b1001,
    OP_OR    = 4'b1010,
    OP_SLL   = 4'b1011,
    OP_SRL   = 4'b1100,
    OP_EQ    = 4'b1101,
    OP_LT    = 4'b1110,
    OP_RXOR  = 4'b1111
  } alu_op_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_t;

  typedef struct packed {
    logic sc_o;
    logic pari;
    logic one;
    logic zero;
    logic err;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_RESET = '{sc_o: 1'b0, pari: 1'b0, one: 1'b0, zero: 1'b1, err: 1'b0};

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      4'b0110: legal = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      4'b0100: legal = 1'b1;
`else
      4'b0100: legal = 1'b0;
`endif
      default: legal = 1'b1;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: W iterations after start, one per clock.
// done is high during the final iteration so product can be captured on that same edge.
module alu_mul_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int SW = $clog2(W);
  localparam logic [SW-1:0] LAST_CNT = SW'(W - 1);

  logic [2*W-1:0] acc_r;
  logic [2*W-1:0] mcand_r;
  logic [W-1:0]   mplier_r;
  logic [SW-1:0]  cnt_r;
  logic           busy_r;
  logic [2*W-1:0] addend_s;

  // Partial product selected by the current multiplier LSB.
  always_comb begin
    addend_s = {(2*W){1'b0}};
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {(2*W){1'b0}};
    end
  end

  assign busy    = busy_r;
  assign done    = busy_r && (cnt_r == LAST_CNT);
  assign product = acc_r + addend_s;

  // Iteration state: load on start, accumulate one bit per cycle while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r    <= {(2*W){1'b0}};
      mcand_r  <= {(2*W){1'b0}};
      mplier_r <= {W{1'b0}};
      cnt_r    <= {SW{1'b0}};
      busy_r   <= 1'b0;
    end else if (start && !busy_r) begin
      acc_r    <= {(2*W){1'b0}};
      mcand_r  <= {{W{1'b0}}, a};
      mplier_r <= b;
      cnt_r    <= {SW{1'b0}};
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      acc_r    <= acc_r + addend_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      if (cnt_r == LAST_CNT) begin
        cnt_r  <= {SW{1'b0}};
        busy_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_r + {{(SW-1){1'b0}}, 1'b1};
        busy_r <= 1'b1;
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered X9 ALU with valid/ready on both sides; results and flags held until consumed.
// Define ALU_SEQ_MUL_EN to enable the multi-cycle MUL opcode (0100); otherwise it is illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] rslt,
  output logic         sc_o,
  output logic         pari,
  output logic         one,
  output logic         zero,
  output logic         err
);
  localparam logic [W-1:0] ONE_V  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO_V = {W{1'b0}};

  function automatic logic parity_f(input logic [W-1:0] v);
    return ^v;
  endfunction

  alu_op_t    op_s;
  alu_state_t state_r;
  logic       out_valid_r;
  logic [W-1:0] rslt_r;
  alu_flags_t flags_r;

  logic         accept_s, consume_s, mul_op_s, mul_done_s, mul_busy_s;
  logic [W-1:0] dp_rslt_s;
  logic         dp_sc_s, dp_err_s;
  logic         ld_en_s, ld_sc_s, ld_err_s;
  logic [W-1:0] ld_rslt_s;
  alu_flags_t   ld_flags_s;

  assign op_s      = alu_op_t'(alu_cmd);
  assign in_ready  = (state_r == ST_IDLE) && !mul_busy_s && (!out_valid_r || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign consume_s = out_valid_r && out_ready;
  assign dp_err_s  = !is_legal_op(alu_cmd);

`ifdef ALU_SEQ_MUL_EN
  logic [2*W-1:0] mul_prod_s;

  assign mul_op_s = (op_s == OP_MUL);

  alu_mul_seq #(.W(W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept_s && mul_op_s),
    .a       (inA),
    .b       (inB),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );
`else
  assign mul_op_s   = 1'b0;
  assign mul_done_s = 1'b0;
  assign mul_busy_s = 1'b0;
`endif

  // Single-cycle datapath; shifts use a one-bit guard so the shifted-out bit falls out naturally.
  always_comb begin
    dp_rslt_s = ZERO_V;
    dp_sc_s   = 1'b0;
    case (op_s)
      OP_ADD:   {dp_sc_s, dp_rslt_s} = {1'b0, inA} + {1'b0, inB};
      OP_SUB:   {dp_sc_s, dp_rslt_s} = {1'b0, inA} - {1'b0, inB};
      OP_ADC:   {dp_sc_s, dp_rslt_s} = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_i};
      OP_PASSA: dp_rslt_s = inA;
      OP_PASSB: dp_rslt_s = inB;
      OP_NOR:   dp_rslt_s = ~(inA | inB);
      OP_XOR:   dp_rslt_s = inA ^ inB;
      OP_AND:   dp_rslt_s = inA & inB;
      OP_OR:    dp_rslt_s = inA | inB;
      OP_SLL:   {dp_sc_s, dp_rslt_s} = {1'b0, inA} << inB;
      OP_SRL:   {dp_rslt_s, dp_sc_s} = {inA, 1'b0} >> inB;
      OP_EQ:    dp_rslt_s = {{(W-1){1'b0}}, (inA == inB)};
      OP_LT:    dp_rslt_s = {{(W-1){1'b0}}, (inA < inB)};
      OP_RXOR:  dp_rslt_s = {{(W-1){1'b0}}, ^inB};
      default: begin
        dp_rslt_s = ZERO_V;
        dp_sc_s   = 1'b0;
      end
    endcase
  end

  // Select what loads into the output registers this edge: a single-cycle result or the product.
  always_comb begin
    ld_en_s   = 1'b0;
    ld_rslt_s = dp_rslt_s;
    ld_sc_s   = dp_sc_s;
    ld_err_s  = dp_err_s;
    if ((state_r == ST_IDLE) && accept_s && !mul_op_s) begin
      ld_en_s = 1'b1;
`ifdef ALU_SEQ_MUL_EN
    end else if ((state_r == ST_BUSY) && mul_done_s) begin
      ld_en_s   = 1'b1;
      ld_rslt_s = mul_prod_s[W-1:0];
      ld_sc_s   = |mul_prod_s[2*W-1:W];
      ld_err_s  = 1'b0;
`endif
    end else begin
      ld_en_s = 1'b0;
    end
    ld_flags_s = '{sc_o: ld_sc_s,
                   pari: parity_f(ld_rslt_s),
                   one:  (ld_rslt_s == ONE_V),
                   zero: (ld_rslt_s == ZERO_V),
                   err:  ld_err_s};
  end

  // FSM plus output/flag registers; a load wins over a consume on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      rslt_r      <= ZERO_V;
      flags_r     <= FLAGS_RESET;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && mul_op_s) begin
            state_r <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mul_done_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        default: state_r <= ST_IDLE;
      endcase

      if (ld_en_s) begin
        out_valid_r <= 1'b1;
        rslt_r      <= ld_rslt_s;
        flags_r     <= ld_flags_s;
      end else if (consume_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign rslt      = rslt_r;
  assign sc_o      = flags_r.sc_o;
  assign pari      = flags_r.pari;
  assign one       = flags_r.one;
  assign zero      = flags_r.zero;
  assign err       = flags_r.err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at W=8; MUL scenarios follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] alu_cmd = 4'h0;
  logic [7:0] inA = 8'h00;
  logic [7:0] inB = 8'h00;
  logic       sc_i = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] rslt;
  logic       sc_o, pari, one, zero, err;

  int tests = 0;
  int fails = 0;

  // op, a, b, ci, expected rslt, sc_o, pari, one, zero, err
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] r;
    logic       sc;
    logic       p;
    logic       o;
    logic       z;
    logic       e;
  } vec_t;

  alu_seq #(.W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_cmd   (alu_cmd),
    .inA       (inA),
    .inB       (inB),
    .sc_i      (sc_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rslt      (rslt),
    .sc_o      (sc_o),
    .pari      (pari),
    .one       (one),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({out_valid, rslt, sc_o, pari, one, zero, err} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", {out_valid, rslt, sc_o, pari, one, zero, err},
               {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single_cycle(input string tag, input vec_t vecs[$]);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      alu_cmd = vecs[i].op;
      inA = vecs[i].a;
      inB = vecs[i].b;
      sc_i = vecs[i].ci;
      out_ready = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      tests++;
      if ({out_valid, rslt, sc_o, pari, one, zero, err} !==
          {1'b1, vecs[i].r, vecs[i].sc, vecs[i].p, vecs[i].o, vecs[i].z, vecs[i].e}) begin
        fails++;
        $display("FAIL %s[%0d] op=%b a=%h b=%h: got v/r/sc/p/o/z/e=%b/%h/%b%b%b%b%b expected %b/%h/%b%b%b%b%b",
                 tag, i, vecs[i].op, vecs[i].a, vecs[i].b,
                 out_valid, rslt, sc_o, pari, one, zero, err,
                 1'b1, vecs[i].r, vecs[i].sc, vecs[i].p, vecs[i].o, vecs[i].z, vecs[i].e);
      end
    end
  endtask

  task automatic test_arith_logic;
    vec_t v[$];
    v.push_back({4'b0000, 8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    v.push_back({4'b0010, 8'd255, 8'd0,   1'b1, 8'd0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    v.push_back({4'b0010, 8'd1,   8'd1,   1'b0, 8'd2,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    v.push_back({4'b0001, 8'd5,   8'd7,   1'b0, 8'd254, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    v.push_back({4'b0001, 8'd7,   8'd5,   1'b1, 8'd2,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    v.push_back({4'b1101, 8'd9,   8'd9,   1'b0, 8'd1,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    v.push_back({4'b1110, 8'd9,   8'd3,   1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    v.push_back({4'b1110, 8'd3,   8'd9,   1'b0, 8'd1,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    v.push_back({4'b1111, 8'hFF,  8'h07,  1'b0, 8'd1,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    v.push_back({4'b0111, 8'hF0,  8'h0C,  1'b0, 8'h03,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back({4'b1000, 8'hAA,  8'h0F,  1'b0, 8'hA5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back({4'b1001, 8'hAA,  8'h0F,  1'b0, 8'h0A,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back({4'b1010, 8'hA0,  8'h05,  1'b0, 8'hA5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back({4'b0011, 8'h37,  8'h00,  1'b1, 8'h37,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    v.push_back({4'b0101, 8'h00,  8'h01,  1'b0, 8'h01,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    test_single_cycle("arith_logic", v);
  endtask

  task automatic test_shift;
    vec_t v[$];
    v.push_back({4'b1011, 8'h81, 8'd1, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    v.push_back({4'b1011, 8'h81, 8'd8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    v.push_back({4'b1011, 8'h81, 8'd9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    v.push_back({4'b1011, 8'h81, 8'd0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back({4'b1100, 8'h81, 8'd1, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    v.push_back({4'b1100, 8'h81, 8'd8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    v.push_back({4'b1100, 8'h81, 8'd9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    v.push_back({4'b1100, 8'h81, 8'd0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    v.push_back({4'b1100, 8'h81, 8'd200, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    test_single_cycle("shift", v);
  endtask

  task automatic test_illegal;
    vec_t v[$];
    v.push_back({4'b0110, 8'h05, 8'h03, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
`ifndef ALU_SEQ_MUL_EN
    v.push_back({4'b0100, 8'h0F, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
`endif
    // a legal op right after an illegal one must clear err
    v.push_back({4'b0000, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    test_single_cycle("illegal", v);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    out_ready = 1'b0;
    alu_cmd = 4'b0000; inA = 8'd1; inB = 8'd2; sc_i = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    alu_cmd = 4'b1000; inA = 8'h0F; inB = 8'hF0;
    for (int c = 0; c < 3; c++) begin
      tests++;
      if ({out_valid, rslt, in_ready} !== {1'b1, 8'd3, 1'b0}) begin
        fails++;
        $display("FAIL backpressure_hold[%0d]: got v/r/in_ready=%b/%h/%b expected 1/03/0",
                 c, out_valid, rslt, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if ({out_valid, rslt, pari, err} !== {1'b1, 8'hFF, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL back_to_back_xor: got v/r/p/e=%b/%h/%b/%b expected 1/ff/0/0", out_valid, rslt, pari, err);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    out_ready = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    alu_cmd = 4'b0100;
`else
    alu_cmd = 4'b0000;
`endif
    inA = 8'd3; inB = 8'd4;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({out_valid, in_ready, zero} !== {1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid_op: got v/in_ready/zero=%b/%b/%b expected 0/1/1", out_valid, in_ready, zero);
    end
    repeat (10) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_op_no_output: got out_valid=%b expected 0", out_valid);
    end
    out_ready = 1'b1;
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic test_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                          input logic sc, input logic p, input logic z);
    @(negedge clk);
    out_ready = 1'b1;
    alu_cmd = 4'b0100; inA = a; inB = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    // after accept edge k and edges k+1..k+7: still busy
    for (int c = 0; c < 8; c++) begin
      tests++;
      if ({out_valid, in_ready} !== 2'b00) begin
        fails++;
        $display("FAIL mul_busy %0d*%0d cyc%0d: got v/in_ready=%b/%b expected 0/0", a, b, c, out_valid, in_ready);
      end
      @(negedge clk);
    end
    tests++;
    if ({out_valid, rslt, sc_o, pari, zero, err} !== {1'b1, r, sc, p, z, 1'b0}) begin
      fails++;
      $display("FAIL mul_result %0d*%0d: got v/r/sc/p/z/e=%b/%h/%b%b%b%b expected 1/%h/%b%b%b0",
               a, b, out_valid, rslt, sc_o, pari, zero, err, r, sc, p, z);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_arith_logic();
    test_shift();
    test_illegal();
    test_back_to_back();
`ifdef ALU_SEQ_MUL_EN
    test_mul(8'd15, 8'd17, 8'd255, 1'b0, 1'b0, 1'b0);
    test_mul(8'd16, 8'd16, 8'd0,   1'b1, 1'b0, 1'b1);
`endif
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
